// File: rtl/pwm_duty_gen.sv
// rtl/pwm_duty_gen.sv - prescaled PWM generator with a one-deep pending duty buffer
// A new duty is staged in the pending buffer and applied only at a period boundary.

module pwm_duty_gen #(
    parameter int DW = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [DW-1:0] duty_in,
    input  logic          duty_valid,
    output logic          duty_ready,
    input  logic [PW-1:0] prescale,
    output logic          pwm_out,
    output logic          period_end,
    output logic          pending
);

    localparam logic [DW-1:0] CNT_MAX = {DW{1'b1}};
    localparam logic [DW-1:0] CNT_ONE = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PRE_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] duty_act_q, duty_act_d;
    logic [DW-1:0] duty_pend_q, duty_pend_d;
    logic          pend_full_q, pend_full_d;
    logic          pwm_q, pwm_d;
    logic          period_end_q, period_end_d;

    logic tick;
    logic boundary;
    logic accept;

    // >= rather than == so that lowering prescale mid-count ticks immediately
    assign tick     = ena && (pre_cnt_q >= prescale);
    assign boundary = tick && (cnt_q == CNT_MAX);
    assign accept   = duty_valid && !pend_full_q;

    assign duty_ready = !pend_full_q;
    assign pending    = pend_full_q;
    assign pwm_out    = pwm_q;
    assign period_end = period_end_q;

    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        cnt_d        = cnt_q;
        duty_act_d   = duty_act_q;
        duty_pend_d  = duty_pend_q;
        pend_full_d  = pend_full_q;
        pwm_d        = 1'b0;
        period_end_d = 1'b0;

        if (!ena) begin
            pre_cnt_d = '0;
            cnt_d     = '0;
            if (pend_full_q) begin
                duty_act_d  = duty_pend_q;
                pend_full_d = 1'b0;
            end
        end else begin
            if (tick) begin
                pre_cnt_d = '0;
                cnt_d     = cnt_q + CNT_ONE;
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_ONE;
            end
            if (boundary && pend_full_q) begin
                duty_act_d  = duty_pend_q;
                pend_full_d = 1'b0;
            end
            pwm_d        = (cnt_q < duty_act_q);
            period_end_d = boundary;
        end

        // accept only happens with pend_full_q low, so it never races the transfer above
        if (accept) begin
            duty_pend_d = duty_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            duty_act_q   <= '0;
            duty_pend_q  <= '0;
            pend_full_q  <= 1'b0;
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            duty_act_q   <= duty_act_d;
            duty_pend_q  <= duty_pend_d;
            pend_full_q  <= pend_full_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

endmodule

// File: tb/tb_pwm_duty_gen.sv
// tb/tb_pwm_duty_gen.sv - directed self-checking bench for pwm_duty_gen
module tb_pwm_duty_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic [3:0] prescale;
    logic       pwm_out;
    logic       period_end;
    logic       pending;

    int n_vec = 0;
    int n_err = 0;

    pwm_duty_gen #(.DW(8), .PW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .prescale   (prescale),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic wait_pe(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (period_end === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_window(input int n, output int hi, output int pe);
        hi = 0;
        pe = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) hi++;
            if (period_end === 1'b1) pe++;
        end
    endtask

    task automatic offer(input logic [7:0] d);
        duty_valid = 1'b1;
        duty_in    = d;
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; duty_valid = 1'b0; duty_in = 8'h00; prescale = 4'd0;
        repeat (3) @(negedge clk);
        n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
        n_vec++; if (period_end !== 1'b0) begin n_err++; $display("FAIL reset_pe got %b want 0", period_end); end
        n_vec++; if (duty_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", duty_ready); end
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got %b want 0", pending); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_duty();
        bit ok; int hi; int pe;
        ena = 1'b1;
        offer(8'h40);
        n_vec++; if (pending !== 1'b1 || duty_ready !== 1'b0) begin n_err++; $display("FAIL basic_accept got pend=%b rdy=%b want 1/0", pending, duty_ready); end
        wait_pe(600, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_wait_pe timeout got 0 want 1"); end
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL basic_applied got pend=%b want 0", pending); end
        count_window(256, hi, pe);
        n_vec++; if (hi !== 64) begin n_err++; $display("FAIL basic_high got %0d want 64", hi); end
        n_vec++; if (pe !== 1 || period_end !== 1'b1) begin n_err++; $display("FAIL basic_pe got %0d/%b want 1/1", pe, period_end); end
    endtask

    task automatic test_back_to_back();
        bit ok; int hi; int hi1; int pe;
        duty_valid = 1'b1; duty_in = 8'h10;
        @(negedge clk);
        duty_in = 8'h20;
        n_vec++; if (duty_ready !== 1'b0 || pending !== 1'b1) begin n_err++; $display("FAIL bp_ready got rdy=%b pend=%b want 0/1", duty_ready, pending); end
        wait_pe(300, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_wait_pe timeout got 0 want 1"); end
        n_vec++; if (pending !== 1'b0 || duty_ready !== 1'b1) begin n_err++; $display("FAIL bp_boundary got pend=%b rdy=%b want 0/1", pending, duty_ready); end
        @(negedge clk);
        duty_valid = 1'b0;
        hi1 = (pwm_out === 1'b1) ? 1 : 0;
        n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL bp_second_accept got pend=%b want 1", pending); end
        count_window(255, hi, pe);
        n_vec++; if (hi + hi1 !== 16) begin n_err++; $display("FAIL bp_first_period got %0d want 16", hi + hi1); end
        n_vec++; if (pe !== 1) begin n_err++; $display("FAIL bp_first_pe got %0d want 1", pe); end
        count_window(256, hi, pe);
        n_vec++; if (hi !== 32) begin n_err++; $display("FAIL bp_second_period got %0d want 32", hi); end
        n_vec++; if (pe !== 1 || pending !== 1'b0) begin n_err++; $display("FAIL bp_second_pe got %0d/%b want 1/0", pe, pending); end
    endtask

    task automatic test_simultaneous();
        int hi; int pe;
        repeat (255) @(negedge clk);
        duty_valid = 1'b1; duty_in = 8'h30;
        @(negedge clk);
        duty_valid = 1'b0;
        n_vec++; if (period_end !== 1'b1 || pending !== 1'b1) begin n_err++; $display("FAIL sim_edge got pe=%b pend=%b want 1/1", period_end, pending); end
        count_window(256, hi, pe);
        n_vec++; if (hi !== 32) begin n_err++; $display("FAIL sim_old_duty got %0d want 32", hi); end
        count_window(256, hi, pe);
        n_vec++; if (hi !== 48) begin n_err++; $display("FAIL sim_new_duty got %0d want 48", hi); end
        n_vec++; if (pe !== 1 || pending !== 1'b0) begin n_err++; $display("FAIL sim_pe got %0d/%b want 1/0", pe, pending); end
    endtask

    task automatic test_prescaler();
        bit ok; int hi; int pe; int n;
        prescale = 4'd3;
        offer(8'h80);
        wait_pe(1200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL pre_wait_pe timeout got 0 want 1"); end
        count_window(1024, hi, pe);
        n_vec++; if (hi !== 512) begin n_err++; $display("FAIL pre_high got %0d want 512", hi); end
        n_vec++; if (pe !== 1 || period_end !== 1'b1) begin n_err++; $display("FAIL pre_period got %0d/%b want 1/1", pe, period_end); end
        repeat (2) @(negedge clk);
        prescale = 4'd1;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n++;
            if (period_end === 1'b1) break;
        end
        n_vec++; if (n !== 511) begin n_err++; $display("FAIL pre_lowered got %0d want 511", n); end
    endtask

    task automatic test_extremes();
        bit ok; int hi; int pe;
        prescale = 4'd0;
        offer(8'h00);
        wait_pe(600, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ext_wait0 timeout got 0 want 1"); end
        count_window(256, hi, pe);
        n_vec++; if (hi !== 0) begin n_err++; $display("FAIL ext_zero got %0d want 0", hi); end
        offer(8'hFF);
        wait_pe(600, ok);
        count_window(256, hi, pe);
        n_vec++; if (hi !== 255 || pe !== 1) begin n_err++; $display("FAIL ext_full got %0d/%0d want 255/1", hi, pe); end
        offer(8'h55);
        n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL ext_pend55 got %b want 1", pending); end
        ena = 1'b0;
        @(negedge clk);
        n_vec++; if (pending !== 1'b0 || pwm_out !== 1'b0 || period_end !== 1'b0) begin n_err++; $display("FAIL ext_ena_off got pend=%b pwm=%b pe=%b want 0/0/0", pending, pwm_out, period_end); end
        repeat (3) @(negedge clk);
        n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL ext_ena_hold got %b want 0", pwm_out); end
        ena = 1'b1;
        count_window(256, hi, pe);
        n_vec++; if (hi !== 85) begin n_err++; $display("FAIL ext_resume_high got %0d want 85", hi); end
        n_vec++; if (pe !== 1 || period_end !== 1'b1) begin n_err++; $display("FAIL ext_resume_pe got %0d/%b want 1/1", pe, period_end); end
    endtask

    task automatic test_reset_mid_period();
        bit ok; int hi; int pe;
        offer(8'h80);
        wait_pe(600, ok);
        repeat (10) @(negedge clk);
        n_vec++; if (pwm_out !== 1'b1) begin n_err++; $display("FAIL rst_pre_pwm got %b want 1", pwm_out); end
        offer(8'h99);
        n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL rst_pre_pend got %b want 1", pending); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (pwm_out !== 1'b0 || duty_ready !== 1'b1 || pending !== 1'b0) begin n_err++; $display("FAIL rst_async got pwm=%b rdy=%b pend=%b want 0/1/0", pwm_out, duty_ready, pending); end
        duty_valid = 1'b1; duty_in = 8'h77;
        repeat (3) @(negedge clk);
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL rst_ignore_valid got %b want 0", pending); end
        duty_valid = 1'b0;
        rst_n = 1'b1;
        count_window(300, hi, pe);
        n_vec++; if (hi !== 0) begin n_err++; $display("FAIL rst_after_high got %0d want 0", hi); end
        n_vec++; if (pe !== 1) begin n_err++; $display("FAIL rst_after_pe got %0d want 1", pe); end
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_back_to_back();
        test_simultaneous();
        test_prescaler();
        test_extremes();
        test_reset_mid_period();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
